// File: rtl/cordic_pkg.sv
// rtl/cordic_pkg.sv - shared CORDIC constants (Q2.30), rescaling helper and FSM state type
package cordic_pkg;

  typedef enum logic [1:0] {S_IDLE, S_PRE, S_ROT, S_POST} state_t;

  localparam logic signed [63:0] K_Q30    = 64'sd652032874;
  localparam logic signed [63:0] PI_Q30   = 64'sd3373259426;
  localparam logic signed [63:0] PI_2_Q30 = 64'sd1686629713;

  // atan(2^-i) in Q2.30; beyond i=9 the value equals 2^-i to within half an LSB
  function automatic logic signed [63:0] atan_q30(input int i);
    case (i)
      0:       return 64'sd843314857;
      1:       return 64'sd497837829;
      2:       return 64'sd263043837;
      3:       return 64'sd133525159;
      4:       return 64'sd67021687;
      5:       return 64'sd33543516;
      6:       return 64'sd16775851;
      7:       return 64'sd8388437;
      8:       return 64'sd4194283;
      9:       return 64'sd2097149;
      default: return (i <= 30) ? (64'sd1 <<< (30 - i)) : 64'sd0;
    endcase
  endfunction

  function automatic logic signed [63:0] rescale_q30(input logic signed [63:0] v, input int fb);
    if (fb <= 30) return v >>> (30 - fb);
    return v <<< (fb - 30);
  endfunction

endpackage

// File: rtl/cordic_stage.sv
// rtl/cordic_stage.sv - one combinational CORDIC micro-rotation, direction chosen by sign of z
module cordic_stage #(
  parameter int DW = 20
) (
  input  logic signed [DW-1:0] i_x,
  input  logic signed [DW-1:0] i_y,
  input  logic signed [DW-1:0] i_z,
  input  logic        [4:0]    i_shift,
  input  logic signed [DW-1:0] i_atan,
  output logic signed [DW-1:0] o_x,
  output logic signed [DW-1:0] o_y,
  output logic signed [DW-1:0] o_z
);

  logic signed [DW-1:0] w_xs;
  logic signed [DW-1:0] w_ys;
  logic                 w_pos;

  assign w_xs  = i_x >>> i_shift;
  assign w_ys  = i_y >>> i_shift;
  assign w_pos = ~i_z[DW-1];

  assign o_x = w_pos ? (i_x - w_ys)    : (i_x + w_ys);
  assign o_y = w_pos ? (i_y + w_xs)    : (i_y - w_xs);
  assign o_z = w_pos ? (i_z - i_atan)  : (i_z + i_atan);

endmodule

// File: rtl/cordic_iter.sv
// rtl/cordic_iter.sv - iterative CORDIC sin/cos, one micro-rotation per clock
// Optional macro CORDIC_ROUND_EN: round half-up when dropping guard bits.
module cordic_iter
  import cordic_pkg::*;
#(
  parameter int W    = 16,
  parameter int FRAC = 13,
  parameter int ITER = 14,
  parameter int G    = 3
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                start,
  input  logic signed [W-1:0] angle_in,
  output logic                ready_out,
  output logic signed [W-1:0] sin_out,
  output logic signed [W-1:0] cos_out
);

  localparam int DW = W + G + 1;
  localparam int FB = FRAC + G;

  localparam logic signed [DW-1:0] K_S    = DW'(rescale_q30(K_Q30, FB));
  localparam logic signed [DW-1:0] PI_S   = DW'(rescale_q30(PI_Q30, FB));
  localparam logic signed [DW-1:0] PI_2_S = DW'(rescale_q30(PI_2_Q30, FB));
  localparam logic signed [DW-1:0] SAT_HI = DW'((64'sd1 <<< (W - 1)) - 64'sd1);
  localparam logic signed [DW-1:0] SAT_LO = DW'(-(64'sd1 <<< (W - 1)));

  state_t               r_state;
  logic signed [W-1:0]  r_angle;
  logic signed [DW-1:0] r_x, r_y, r_z;
  logic        [4:0]    r_iter;
  logic                 r_neg;
  logic                 r_ready;
  logic signed [W-1:0]  r_sin, r_cos;

  logic signed [DW-1:0] w_a;
  logic signed [DW-1:0] w_x_nxt, w_y_nxt, w_z_nxt;
  logic signed [DW-1:0] w_x_drop, w_y_drop, w_cos_n, w_sin_n;
  logic signed [DW-1:0] w_atan_tab [32];

  for (genvar k = 0; k < 32; k++) begin : g_atan
    assign w_atan_tab[k] = DW'(rescale_q30(atan_q30(k), FB));
  end

  assign w_a = {{(G + 1){r_angle[W-1]}}, r_angle} <<< G;

  cordic_stage #(.DW(DW)) u_stage (
    .i_x    (r_x),
    .i_y    (r_y),
    .i_z    (r_z),
    .i_shift(r_iter),
    .i_atan (w_atan_tab[r_iter]),
    .o_x    (w_x_nxt),
    .o_y    (w_y_nxt),
    .o_z    (w_z_nxt)
  );

`ifdef CORDIC_ROUND_EN
  localparam logic signed [DW-1:0] RND = DW'(64'sd1 <<< (G - 1));
  assign w_x_drop = (r_x + RND) >>> G;
  assign w_y_drop = (r_y + RND) >>> G;
`else
  assign w_x_drop = r_x >>> G;
  assign w_y_drop = r_y >>> G;
`endif

  // Negate at full width so the most negative W-bit value cannot wrap
  assign w_cos_n = r_neg ? -w_x_drop : w_x_drop;
  assign w_sin_n = r_neg ? -w_y_drop : w_y_drop;

  function automatic logic signed [W-1:0] sat(input logic signed [DW-1:0] v);
    if (v > SAT_HI) return SAT_HI[W-1:0];
    if (v < SAT_LO) return SAT_LO[W-1:0];
    return v[W-1:0];
  endfunction

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_angle <= '0;
      r_x     <= '0;
      r_y     <= '0;
      r_z     <= '0;
      r_iter  <= '0;
      r_neg   <= 1'b0;
      r_ready <= 1'b0;
      r_sin   <= '0;
      r_cos   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_angle <= angle_in;
            r_ready <= 1'b0;
            r_state <= S_PRE;
          end
        end
        S_PRE: begin
          if (w_a > PI_2_S) begin
            r_z   <= w_a - PI_S;
            r_neg <= 1'b1;
          end else if (w_a < -PI_2_S) begin
            r_z   <= w_a + PI_S;
            r_neg <= 1'b1;
          end else begin
            r_z   <= w_a;
            r_neg <= 1'b0;
          end
          r_x     <= K_S;
          r_y     <= '0;
          r_iter  <= '0;
          r_state <= S_ROT;
        end
        S_ROT: begin
          r_x    <= w_x_nxt;
          r_y    <= w_y_nxt;
          r_z    <= w_z_nxt;
          r_iter <= r_iter + 5'd1;
          if (r_iter == 5'(ITER - 1)) r_state <= S_POST;
        end
        S_POST: begin
          r_sin   <= sat(w_sin_n);
          r_cos   <= sat(w_cos_n);
          r_ready <= 1'b1;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign ready_out = r_ready;
  assign sin_out   = r_sin;
  assign cos_out   = r_cos;

endmodule

// File: tb/tb_cordic_iter.sv
// tb/tb_cordic_iter.sv - directed checks of cordic_iter at default parameters
module tb_cordic_iter;

  logic               clock = 1'b0;
  logic               reset;
  logic               start;
  logic signed [15:0] angle_in;
  logic               ready_out;
  logic signed [15:0] sin_out;
  logic signed [15:0] cos_out;

  int checks = 0;
  int errors = 0;
  int lat;

  int vec_a [6] = '{12868, -4289, 25736, -19302, 6434, -12868};
  int vec_s [6] = '{ 8192, -4096,     0,  -5793, 5793,  -8192};
  int vec_c [6] = '{    0,  7094, -8192,  -5793, 5793,      0};

  always #5 clock = ~clock;

  cordic_iter dut (
    .clock    (clock),
    .reset    (reset),
    .start    (start),
    .angle_in (angle_in),
    .ready_out(ready_out),
    .sin_out  (sin_out),
    .cos_out  (cos_out)
  );

  task automatic chk_eq(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_near(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    checks++;
    assert (((obs - exp) <= 2) && ((exp - obs) <= 2)) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d (+/-2)", tag, obs, exp);
    end
  endtask

  task automatic wait_ready(inout int n);
    while (ready_out !== 1'b1 && n < 64) begin
      @(negedge clock);
      n++;
    end
  endtask

  // Called at a negedge; returns edges from the sampling edge to ready_out high
  task automatic run_op(input int a, output int n);
    angle_in = 16'(a);
    start    = 1'b1;
    @(negedge clock);
    start = 1'b0;
    n     = 0;
    wait_ready(n);
  endtask

  initial begin
    reset    = 1'b1;
    start    = 1'b0;
    angle_in = '0;
    repeat (3) @(negedge clock);
    chk_eq("rst_ready", ready_out, 0);
    chk_eq("rst_sin", sin_out, 0);
    chk_eq("rst_cos", cos_out, 0);
    reset = 1'b0;
    @(negedge clock);

    run_op(0, lat);
    chk_eq("lat_zero", lat, 16);
    chk_near("sin_zero", sin_out, 0);
    chk_near("cos_zero", cos_out, 8192);
    repeat (5) @(negedge clock);
    chk_eq("ready_held", ready_out, 1);
    chk_near("cos_zero_held", cos_out, 8192);

    for (int v = 0; v < 6; v++) begin
      run_op(vec_a[v], lat);
      chk_eq($sformatf("lat_a%0d", vec_a[v]), lat, 16);
      chk_near($sformatf("sin_a%0d", vec_a[v]), sin_out, vec_s[v]);
      chk_near($sformatf("cos_a%0d", vec_a[v]), cos_out, vec_c[v]);
    end

    // start re-pulsed while rotating must be ignored
    angle_in = -16'sd4289;
    start    = 1'b1;
    @(negedge clock);
    start = 1'b0;
    repeat (5) @(negedge clock);
    start    = 1'b1;
    angle_in = 16'sd12868;
    @(negedge clock);
    start = 1'b0;
    lat   = 6;
    wait_ready(lat);
    chk_eq("repulse_lat", lat, 16);
    chk_near("repulse_sin", sin_out, -4096);
    repeat (20) @(negedge clock);
    chk_eq("repulse_single", ready_out, 1);
    chk_near("repulse_cos", cos_out, 7094);

    // start held high: back-to-back results
    angle_in = '0;
    start    = 1'b1;
    @(negedge clock);
    lat = 0;
    wait_ready(lat);
    chk_eq("b2b_lat1", lat, 16);
    chk_near("b2b_cos1", cos_out, 8192);
    angle_in = 16'sd6434;
    @(negedge clock);
    start = 1'b0;
    chk_eq("b2b_fall", ready_out, 0);
    chk_near("b2b_hold_cos", cos_out, 8192);
    chk_near("b2b_hold_sin", sin_out, 0);
    lat = 0;
    wait_ready(lat);
    chk_eq("b2b_lat2", lat, 16);
    chk_near("b2b_sin2", sin_out, 5793);

    // reset in the middle of rotation aborts the computation
    angle_in = -16'sd4289;
    start    = 1'b1;
    @(negedge clock);
    start = 1'b0;
    repeat (6) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    chk_eq("abort_ready", ready_out, 0);
    chk_eq("abort_sin", sin_out, 0);
    chk_eq("abort_cos", cos_out, 0);
    reset = 1'b0;
    repeat (30) @(negedge clock);
    chk_eq("abort_no_result", ready_out, 0);
    run_op(-4289, lat);
    chk_eq("after_abort_lat", lat, 16);
    chk_near("after_abort_sin", sin_out, -4096);
    chk_near("after_abort_cos", cos_out, 7094);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
